alu_vector_checker: RTL
=======================

# alu_vector_checker

Synthesizable, self-checking test-vector sequencer for the Hack `alu`. It fetches 56-bit vectors from a synchronous vector ROM and drives the ALU inputs from them. It then compares the ALU's `out`/`zr`/`ng` against the expected fields, counts mismatches, and reports pass/fail. It sits beside `alu` in on-board bring-up builds, so the ALU vector suite runs in hardware rather than only in simulation.

## Interface
Parameters:
- `ADDR_W`, default 10: vector ROM address width; maximum suite length is 2^ADDR_W vectors.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `num_vectors`  in  ADDR_W+1  vector count for the run; sampled when `start` is accepted.
- `vec_addr`  out  ADDR_W  registered ROM address.
- `vec_data`  in  56  ROM data, valid the cycle after `vec_addr` is presented.
  - Layout: [55:40] x, [39:24] y, [23] zx, [22] nx, [21] zy, [20] ny, [19] f, [18] no, [17:2] expected out, [1] expected zr, [0] expected ng.
- `alu_x`, `alu_y`  out  16  registered ALU operands.
- `alu_zx`, `alu_nx`, `alu_zy`, `alu_ny`, `alu_f`, `alu_no`  out  1 each  registered ALU controls.
- `alu_out`  in  16  ALU result (combinational from drive regs).
- `alu_zr`, `alu_ng`  in  1 each  ALU flags.
- `busy`  out  1  high in FETCH/APPLY/CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done` and `err_count`==0.
- `err_count`  out  16  mismatch count; saturates at 16'hFFFF.
- `err_pulse`  out  1  one-cycle strobe per mismatching vector.
- `err_index`  out  ADDR_W  index of the vector flagged by `err_pulse`; holds its value.
- `first_err_idx`  out  ADDR_W  index of the first mismatch in the run.
- `first_err_valid`  out  1  set on the first mismatch in the run.

## Operation
- **Reset:** all outputs 0, state IDLE, index 0.
- **IDLE / DONE with `start`=1:**
  - Clear `err_count`, `first_err_valid`, `err_index`, `first_err_idx`.
  - Latch `num_vectors`; set idx=0 and `vec_addr`=0.
  - Go to FETCH. If `num_vectors`==0, go directly to DONE (`pass`=1).
- **FETCH:** `vec_addr`=idx is on the bus; the ROM captures it. Next state APPLY.
- **APPLY:** latch `vec_data` fields into the ALU drive regs and the expected regs. Next state CHECK.
- **CHECK:** mismatch = (`alu_out`≠exp_out) | (`alu_zr`≠exp_zr) | (`alu_ng`≠exp_ng).
  - On mismatch: `err_count`+1 (saturating), `err_pulse`=1 next cycle, `err_index`=idx.
  - If `first_err_valid`==0: `first_err_idx`=idx and `first_err_valid`=1.
  - If idx == latched count−1: go to DONE.
  - Else: idx+1, `vec_addr`+1, go to FETCH.
- **DONE:** hold all results. `start` re-runs from vector 0.
- `start` is ignored while `busy`.
- `num_vectors` changes after acceptance have no effect.
- Counts above 2^ADDR_W are clamped to 2^ADDR_W.
- Drive regs hold their last vector values in DONE and IDLE; reset zeroes them.
- **Reset mid-run:** aborts immediately. Next cycle is IDLE with all outputs 0; no partial `done`.

## Timing
- 3 cycles per vector (FETCH, APPLY, CHECK).
- `start` accepted at edge 0 → FETCH at cycle 1 → `done` asserted at cycle 3N+1 for N≥1.
- N=0: `done` asserted at cycle 1.
- ALU outputs are sampled one full cycle after the drive regs update. The ALU's combinational path must close within one `clk` period.
- `err_pulse` asserts in the cycle after the CHECK that detected the mismatch; this is the cycle `err_count` shows the new value.
- `err_pulse` lines up with the following FETCH, or with the first DONE cycle.
- `pass` and `done` assert in the same cycle.

## Test plan
- **Golden ALU, 18-vector Hack op suite** (0, 1, −1, x, y, !x, −x, x+1, x+y, x−y, x&y, x|y, … with x=16'h0011, y=16'h0003), `num_vectors`=18:
  - `done` at cycle 55, `pass`=1, `err_count`=0, no `err_pulse`.
- **Same suite, expected-out of vector 5 corrupted to 16'h1234:**
  - Exactly one `err_pulse`, `err_index`=5, `first_err_idx`=5.
  - `err_count`=1, `pass`=0.
- **Vector with expected zr wrong only** (x=y=0, zx=zy=1, f=1, out=0, exp zr=0): mismatch flagged; confirms flag compare.
- **`num_vectors`=0:** `done`=`pass`=1 one cycle after `start`, `vec_addr` stays 0.
- **`reset` pulsed in the APPLY of vector 3, then `start` again:**
  - Cycle after `reset`: all outputs 0.
  - Rerun completes with counters from zero.
- **`start` held high for the whole run, then DONE:**
  - No restart while `busy`.
  - Rerun begins the cycle after DONE is entered; `err_count` clears.

Source files
------------

// File: rtl/alu_vector_checker.sv
// Hardware test-vector sequencer for the Hack ALU: fetches vectors from a synchronous ROM,
// drives the ALU, compares its result and flags, and reports mismatch statistics.
module alu_vector_checker #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vectors,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [55:0]       vec_data,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic              err_pulse,
  output logic [ADDR_W-1:0] err_index,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic              first_err_valid
);

  typedef enum logic [2:0] {IDLE, FETCH, APPLY, CHECK, DONE} state_t;

  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_COUNT = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   clamped;
  logic [ADDR_W:0]   last_idx;
  logic [15:0]       exp_out;
  logic              exp_zr;
  logic              exp_ng;
  logic              mismatch;
  logic              last;

  // Suites longer than the ROM can hold would wrap the address, so clamp to its depth.
  assign clamped  = (num_vectors > MAX_COUNT) ? MAX_COUNT : num_vectors;
  assign last_idx = count - ONE_COUNT;
  assign last     = ({1'b0, idx} == last_idx);
  assign mismatch = (alu_out != exp_out) | (alu_zr != exp_zr) | (alu_ng != exp_ng);
  assign pass     = done & (err_count == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      count           <= '0;
      vec_addr        <= '0;
      alu_x           <= '0;
      alu_y           <= '0;
      alu_zx          <= 1'b0;
      alu_nx          <= 1'b0;
      alu_zy          <= 1'b0;
      alu_ny          <= 1'b0;
      alu_f           <= 1'b0;
      alu_no          <= 1'b0;
      exp_out         <= '0;
      exp_zr          <= 1'b0;
      exp_ng          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_count       <= '0;
      err_pulse       <= 1'b0;
      err_index       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            err_index       <= '0;
            first_err_idx   <= '0;
            count           <= clamped;
            idx             <= '0;
            vec_addr        <= '0;
            if (clamped == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        FETCH: state <= APPLY;
        APPLY: begin
          alu_x   <= vec_data[55:40];
          alu_y   <= vec_data[39:24];
          alu_zx  <= vec_data[23];
          alu_nx  <= vec_data[22];
          alu_zy  <= vec_data[21];
          alu_ny  <= vec_data[20];
          alu_f   <= vec_data[19];
          alu_no  <= vec_data[18];
          exp_out <= vec_data[17:2];
          exp_zr  <= vec_data[1];
          exp_ng  <= vec_data[0];
          state   <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            err_pulse <= 1'b1;
            err_index <= idx;
            if (!first_err_valid) begin
              first_err_idx   <= idx;
              first_err_valid <= 1'b1;
            end
          end
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx      <= idx + ADDR_W'(1);
            vec_addr <= idx + ADDR_W'(1);
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
